// File: rtl/i2c_defs_pkg.sv
// Shared definitions for the BME280 I2C target model.
//   - FSM state encoding
//   - ACK/NACK bus levels
//   - byte and bit-counter sizing
//   - the address-match helper
package i2c_defs;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_ADDR     = 3'd1;
    localparam logic [STATE_W-1:0] ST_ADDR_ACK = 3'd2;
    localparam logic [STATE_W-1:0] ST_PTR      = 3'd3;
    localparam logic [STATE_W-1:0] ST_WDATA    = 3'd4;
    localparam logic [STATE_W-1:0] ST_RDATA    = 3'd5;
    localparam logic [STATE_W-1:0] ST_WAIT     = 3'd6;
    localparam logic [STATE_W-1:0] ST_IGNORE   = 3'd7;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned BIT_CNT_W     = 4;

    // Count value reached on the rise of the last data bit, and the ACK slot value.
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(BITS_PER_BYTE - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_ACK  = BIT_CNT_W'(BITS_PER_BYTE);

    // True when the upper seven bits of an address byte select this target.
    function automatic logic addrMatch(input logic [7:0] addrByte, input logic [6:0] slaveAddr);
        return addrByte[7:1] == slaveAddr;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer and bus-condition detector.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   sclIn      raw SCL line
//   sdaIn      raw SDA line
//   scl_rise   synchronized SCL low->high
//   scl_fall   synchronized SCL high->low
//   start_det  SDA fall while SCL is high in the current and previous sample
//   stop_det   SDA rise while SCL is high in the current and previous sample
//   sda_s      synchronized SDA level
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclIn,
    input  logic sdaIn,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] sclSync;
    logic [SYNC_STAGES-1:0] sdaSync;
    logic                   sclPrev;
    logic                   sdaPrev;
    logic                   sclS;

    assign sclS  = sclSync[SYNC_STAGES-1];
    assign sda_s = sdaSync[SYNC_STAGES-1];

    // Synchronizer chains plus one previous-sample stage; reset to the idle-bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclSync <= '1;
            sdaSync <= '1;
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclSync <= {sclSync[SYNC_STAGES-2:0], sclIn};
            sdaSync <= {sdaSync[SYNC_STAGES-2:0], sdaIn};
            sclPrev <= sclS;
            sdaPrev <= sda_s;
        end
    end

    assign scl_rise  =  sclS & ~sclPrev;
    assign scl_fall  = ~sclS &  sclPrev;
    assign start_det =  sclS &  sclPrev &  sdaPrev & ~sda_s;
    assign stop_det  =  sclS &  sclPrev & ~sdaPrev &  sda_s;

endmodule

// File: rtl/bme280_i2c_slave.sv
// I2C target emulating the BME280 register interface against an external
// 256x8 register file, with burst write/read and pointer auto-increment.
// Ports:
//   Clk, Rst    system clock (>= 16x SCL), synchronous active-high reset
//   SclPadIn    SCL line (no clock stretching)
//   SdaPadIn    SDA line
//   SdaPadOut   constant 0 (open drain)
//   SdaPadEn    1 = release SDA, 0 = pull low
//   RegAddr     register pointer
//   RegWrData   write byte, valid with RegWr
//   RegWr       1-cycle write strobe
//   RegRd       1-cycle read request; RegRdData captured the cycle after
//   RegRdData   read data from the register file
//   Busy        high from matched-address ACK until STOP / restart
module bme280_i2c_slave
    import i2c_defs::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h76,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       SclPadIn,
    input  logic       SdaPadIn,
    output logic       SdaPadOut,
    output logic       SdaPadEn,
    output logic [7:0] RegAddr,
    output logic [7:0] RegWrData,
    output logic       RegWr,
    output logic       RegRd,
    input  logic [7:0] RegRdData,
    output logic       Busy
);

    logic sclRise;
    logic sclFall;
    logic startDet;
    logic stopDet;
    logic sdaS;

    logic [STATE_W-1:0]   state,    stateNext;
    logic [BIT_CNT_W-1:0] bitCnt,   bitCntNext;
    logic [7:0]           shiftReg, shiftRegNext;
    logic                 ackDrv,   ackDrvNext;
    logic                 rwBit,    rwBitNext;
    logic                 rdLoad,   rdLoadNext;
    logic                 sdaEnNext;
    logic [7:0]           regAddrNext;
    logic [7:0]           regWrDataNext;
    logic                 regWrNext;
    logic                 regRdNext;
    logic                 busyNext;
    logic [7:0]           rxByte;

    assign SdaPadOut = 1'b0;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) uLineSync (
        .clk       (Clk),
        .rst       (Rst),
        .sclIn     (SclPadIn),
        .sdaIn     (SdaPadIn),
        .scl_rise  (sclRise),
        .scl_fall  (sclFall),
        .start_det (startDet),
        .stop_det  (stopDet),
        .sda_s     (sdaS)
    );

    // State and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            bitCnt    <= '0;
            shiftReg  <= 8'h00;
            ackDrv    <= 1'b0;
            rwBit     <= 1'b0;
            rdLoad    <= 1'b0;
            SdaPadEn  <= 1'b1;
            RegAddr   <= 8'h00;
            RegWrData <= 8'h00;
            RegWr     <= 1'b0;
            RegRd     <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            bitCnt    <= bitCntNext;
            shiftReg  <= shiftRegNext;
            ackDrv    <= ackDrvNext;
            rwBit     <= rwBitNext;
            rdLoad    <= rdLoadNext;
            SdaPadEn  <= sdaEnNext;
            RegAddr   <= regAddrNext;
            RegWrData <= regWrDataNext;
            RegWr     <= regWrNext;
            RegRd     <= regRdNext;
            Busy      <= busyNext;
        end
    end

    // Next-state and output logic.
    always_comb begin
        stateNext     = state;
        bitCntNext    = bitCnt;
        shiftRegNext  = shiftReg;
        ackDrvNext    = ackDrv;
        rwBitNext     = rwBit;
        rdLoadNext    = RegRd;
        sdaEnNext     = SdaPadEn;
        regAddrNext   = RegAddr;
        regWrDataNext = RegWrData;
        regWrNext     = 1'b0;
        regRdNext     = 1'b0;
        busyNext      = Busy;
        rxByte        = {shiftReg[6:0], sdaS};

        // The file latches the byte at the old pointer on the strobe edge; advance after it.
        if (RegWr) begin
            regAddrNext = RegAddr + 8'd1;
        end

        // Read data requested last cycle is captured here, well before the next SCL fall.
        if (rdLoad) begin
            shiftRegNext = RegRdData;
        end

        if (startDet) begin
            stateNext  = ST_ADDR;
            bitCntNext = '0;
            ackDrvNext = 1'b0;
            sdaEnNext  = 1'b1;
            busyNext   = 1'b0;
        end else if (stopDet) begin
            stateNext  = ST_IDLE;
            bitCntNext = '0;
            ackDrvNext = 1'b0;
            sdaEnNext  = 1'b1;
            busyNext   = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (sclRise && (bitCnt != BIT_CNT_ACK)) begin
                        shiftRegNext = rxByte;
                        bitCntNext   = bitCnt + BIT_CNT_W'(1);
                        if (bitCnt == BIT_CNT_LAST) begin
                            case (state)
                                ST_ADDR: begin
                                    rwBitNext = rxByte[0];
                                    stateNext = addrMatch(rxByte, SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                                end
                                ST_PTR: begin
                                    regAddrNext = rxByte;
                                end
                                default: begin
                                    regWrDataNext = rxByte;
                                    regWrNext     = 1'b1;
                                end
                            endcase
                        end
                    end else if (sclFall && (bitCnt == BIT_CNT_ACK)) begin
                        // First fall after the byte drives ACK, the next one ends the ACK slot.
                        if (!ackDrv) begin
                            sdaEnNext  = I2C_ACK;
                            ackDrvNext = 1'b1;
                        end else begin
                            sdaEnNext  = 1'b1;
                            ackDrvNext = 1'b0;
                            bitCntNext = '0;
                            if (state == ST_PTR) begin
                                stateNext = ST_WDATA;
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (sclFall) begin
                        if (!ackDrv) begin
                            sdaEnNext  = I2C_ACK;
                            ackDrvNext = 1'b1;
                            busyNext   = 1'b1;
                        end else begin
                            ackDrvNext = 1'b0;
                            bitCntNext = '0;
                            if (rwBit) begin
                                stateNext = ST_RDATA;
                                sdaEnNext = shiftReg[7];
                            end else begin
                                stateNext = ST_PTR;
                                sdaEnNext = 1'b1;
                            end
                        end
                    end else if (sclRise && ackDrv && rwBit) begin
                        regRdNext = 1'b1;
                    end
                end

                ST_RDATA: begin
                    if (sclRise) begin
                        if (bitCnt != BIT_CNT_ACK) begin
                            shiftRegNext = {shiftReg[6:0], 1'b0};
                            bitCntNext   = bitCnt + BIT_CNT_W'(1);
                            if (bitCnt == BIT_CNT_LAST) begin
                                regAddrNext = RegAddr + 8'd1;
                            end
                        end else if (sdaS == I2C_NACK) begin
                            stateNext = ST_WAIT;
                        end else begin
                            regRdNext  = 1'b1;
                            bitCntNext = '0;
                        end
                    end else if (sclFall) begin
                        // Master owns SDA during its ACK slot.
                        sdaEnNext = (bitCnt == BIT_CNT_ACK) ? 1'b1 : shiftReg[7];
                    end
                end

                ST_IDLE, ST_WAIT, ST_IGNORE: begin
                    sdaEnNext = 1'b1;
                end

                default: begin
                    stateNext = ST_IDLE;
                    sdaEnNext = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bme280_i2c_slave.sv
// Directed bench for bme280_i2c_slave: bit-banged I2C master, open-drain bus,
// and a 256x8 register file model with registered read.
`timescale 1ns/1ps
module tb_bme280_i2c_slave;

    localparam int Q = 20;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       sclM = 1'b1;
    logic       sdaM = 1'b1;
    logic       SclPadIn;
    logic       SdaPadIn;
    logic       SdaPadOut;
    logic       SdaPadEn;
    logic [7:0] RegAddr;
    logic [7:0] RegWrData;
    logic       RegWr;
    logic       RegRd;
    logic [7:0] RegRdData = 8'h00;
    logic       Busy;
    logic       sdaBus;

    logic [7:0] mem [256];
    int         wrCount = 0;
    int         rdCount = 0;
    int         busyCycles = 0;
    logic [7:0] lastWrAddr = 8'h00;
    logic [7:0] lastWrData = 8'h00;

    int compCnt = 0;
    int failCnt = 0;

    assign sdaBus   = sdaM & (SdaPadEn ? 1'b1 : SdaPadOut);
    assign SclPadIn = sclM;
    assign SdaPadIn = sdaBus;

    always #5 Clk = ~Clk;

    bme280_i2c_slave #(
        .SLAVE_ADDR  (7'h76),
        .SYNC_STAGES (2)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .SclPadIn  (SclPadIn),
        .SdaPadIn  (SdaPadIn),
        .SdaPadOut (SdaPadOut),
        .SdaPadEn  (SdaPadEn),
        .RegAddr   (RegAddr),
        .RegWrData (RegWrData),
        .RegWr     (RegWr),
        .RegRd     (RegRd),
        .RegRdData (RegRdData),
        .Busy      (Busy)
    );

    // Register file model; fixed contents are (re)loaded during reset.
    always @(posedge Clk) begin
        if (Rst) begin
            mem[8'hF5] <= 8'hA5;
            mem[8'hF7] <= 8'h80;
            mem[8'hF8] <= 8'h00;
            mem[8'hF9] <= 8'h00;
            mem[8'h10] <= 8'h00;
        end
        if (RegWr) begin
            mem[RegAddr] <= RegWrData;
            lastWrAddr   <= RegAddr;
            lastWrData   <= RegWrData;
            wrCount      <= wrCount + 1;
        end
        if (RegRd) begin
            RegRdData <= mem[RegAddr];
            rdCount   <= rdCount + 1;
        end
        if (Busy) busyCycles <= busyCycles + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, required finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitQ();
        repeat (Q) @(negedge Clk);
    endtask

    task automatic i2cStart();
        sdaM = 1'b1; sclM = 1'b1; waitQ();
        sdaM = 1'b0; waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic i2cRestart();
        sdaM = 1'b1; waitQ();
        sclM = 1'b1; waitQ();
        sdaM = 1'b0; waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic i2cStop();
        sdaM = 1'b0; waitQ();
        sclM = 1'b1; waitQ();
        sdaM = 1'b1; waitQ();
        waitQ();
    endtask

    task automatic sendBit(input logic b);
        sdaM = b; waitQ();
        sclM = 1'b1; waitQ();
        waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic recvBit(output logic b);
        sdaM = 1'b1; waitQ();
        sclM = 1'b1; waitQ();
        b = sdaBus; waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) sendBit(d[i]);
        recvBit(ack);
    endtask

    task automatic readByte(input logic ackBit, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recvBit(b);
            d[i] = b;
        end
        sendBit(ackBit);
    endtask

    logic       a0, a1, a2, a3;
    logic [7:0] d0, d1, d2;
    int         wr0, rd0, busy0;

    initial begin
        repeat (5) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        // Reset state
        check("rst_sdaen", 32'(SdaPadEn), 32'h1);
        check("rst_sdaout", 32'(SdaPadOut), 32'h0);
        check("rst_regwr", 32'(RegWr), 32'h0);
        check("rst_regrd", 32'(RegRd), 32'h0);
        check("rst_regaddr", 32'(RegAddr), 32'h00);
        check("rst_wrdata", 32'(RegWrData), 32'h00);
        check("rst_busy", 32'(Busy), 32'h0);

        // Single register write: F4 <= 27
        i2cStart();
        writeByte(8'hEC, a0);
        check("w1_busy_after_ack", 32'(Busy), 32'h1);
        writeByte(8'hF4, a1);
        writeByte(8'h27, a2);
        i2cStop();
        check("w1_ack_addr", 32'(a0), 32'h0);
        check("w1_ack_ptr", 32'(a1), 32'h0);
        check("w1_ack_data", 32'(a2), 32'h0);
        check("w1_wrcount", 32'(wrCount), 32'd1);
        check("w1_wraddr", 32'(lastWrAddr), 32'hF4);
        check("w1_wrdata", 32'(lastWrData), 32'h27);
        check("w1_regwrdata", 32'(RegWrData), 32'h27);
        check("w1_ptr_inc", 32'(RegAddr), 32'hF5);
        check("w1_busy_after_stop", 32'(Busy), 32'h0);

        // Pointer write, repeated START, 3-byte read F7..F9
        rd0 = rdCount;
        i2cStart();
        writeByte(8'hEC, a0);
        writeByte(8'hF7, a1);
        i2cRestart();
        writeByte(8'hED, a2);
        readByte(1'b0, d0);
        readByte(1'b0, d1);
        readByte(1'b1, d2);
        i2cStop();
        check("r3_ack_addr_w", 32'(a0), 32'h0);
        check("r3_ack_ptr", 32'(a1), 32'h0);
        check("r3_ack_addr_r", 32'(a2), 32'h0);
        check("r3_byte0", 32'(d0), 32'h80);
        check("r3_byte1", 32'(d1), 32'h00);
        check("r3_byte2", 32'(d2), 32'h00);
        check("r3_rdcount", 32'(rdCount - rd0), 32'd3);
        check("r3_ptr_end", 32'(RegAddr), 32'hFA);
        check("r3_sda_released", 32'(SdaPadEn), 32'h1);

        // Burst read of F4,F5 returns the written byte then a preset byte
        rd0 = rdCount;
        i2cStart();
        writeByte(8'hEC, a0);
        writeByte(8'hF4, a1);
        i2cRestart();
        writeByte(8'hED, a2);
        readByte(1'b0, d0);
        readByte(1'b1, d1);
        i2cStop();
        check("r2_byte0", 32'(d0), 32'h27);
        check("r2_byte1", 32'(d1), 32'hA5);
        check("r2_rdcount", 32'(rdCount - rd0), 32'd2);
        check("r2_ptr_end", 32'(RegAddr), 32'hF6);

        // Foreign address 0x77: NACK, no strobes, never busy
        wr0 = wrCount; rd0 = rdCount; busy0 = busyCycles;
        i2cStart();
        writeByte(8'hEE, a0);
        writeByte(8'h55, a1);
        i2cStop();
        check("na_nack", 32'(a0), 32'h1);
        check("na_nack_data", 32'(a1), 32'h1);
        check("na_wrcount", 32'(wrCount - wr0), 32'd0);
        check("na_rdcount", 32'(rdCount - rd0), 32'd0);
        check("na_busy", 32'(busyCycles - busy0), 32'd0);

        // Burst write across the FF->00 wrap
        wr0 = wrCount;
        i2cStart();
        writeByte(8'hEC, a0);
        writeByte(8'hFF, a1);
        writeByte(8'h11, a2);
        writeByte(8'h22, a3);
        i2cStop();
        check("wrap_ack_d1", 32'(a2), 32'h0);
        check("wrap_ack_d2", 32'(a3), 32'h0);
        check("wrap_wrcount", 32'(wrCount - wr0), 32'd2);
        check("wrap_memFF", 32'(mem[8'hFF]), 32'h11);
        check("wrap_mem00", 32'(mem[8'h00]), 32'h22);
        check("wrap_ptr_end", 32'(RegAddr), 32'h01);

        // STOP after 4 bits of a data byte
        wr0 = wrCount;
        i2cStart();
        writeByte(8'hEC, a0);
        writeByte(8'h10, a1);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        i2cStop();
        check("part_wrcount", 32'(wrCount - wr0), 32'd0);
        check("part_ptr_kept", 32'(RegAddr), 32'h10);
        check("part_busy", 32'(Busy), 32'h0);
        check("part_sda_released", 32'(SdaPadEn), 32'h1);

        // Reset while the target drives a 0 data bit (mem[10] = 00)
        i2cStart();
        writeByte(8'hED, a0);
        check("rr_ack", 32'(a0), 32'h0);
        check("rr_driving_zero", 32'(SdaPadEn), 32'h0);
        Rst = 1'b1;
        @(negedge Clk);
        check("rr_release_next_cycle", 32'(SdaPadEn), 32'h1);
        check("rr_busy", 32'(Busy), 32'h0);
        check("rr_ptr", 32'(RegAddr), 32'h00);
        Rst = 1'b0;
        @(negedge Clk);
        i2cStop();

        // Full write then read-back after the reset
        i2cStart();
        writeByte(8'hEC, a0);
        writeByte(8'h20, a1);
        writeByte(8'h5A, a2);
        i2cStop();
        i2cStart();
        writeByte(8'hEC, a3);
        writeByte(8'h20, a1);
        i2cRestart();
        writeByte(8'hED, a2);
        readByte(1'b1, d0);
        i2cStop();
        check("post_ack_addr", 32'(a0), 32'h0);
        check("post_ack_addr2", 32'(a3), 32'h0);
        check("post_mem20", 32'(mem[8'h20]), 32'h5A);
        check("post_readback", 32'(d0), 32'h5A);
        check("post_ptr_end", 32'(RegAddr), 32'h21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
        $finish;
    end

endmodule
